// File: rtl/keypad_scan_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_debounce_pkg
//  Description : Shared state encoding, row reset pattern and one-hot helpers
//                for the 4x4 keypad scanner.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_scan_debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t     c_st_scan     = 2'd0;
    localparam state_t     c_st_press_db = 2'd1;
    localparam state_t     c_st_pressed  = 2'd2;
    localparam state_t     c_st_rel_db   = 2'd3;

    localparam logic [3:0] c_row_reset   = 4'b0001;

    // True when exactly one bit of v is set.
    function automatic logic onehot_single(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Index of the lowest set bit; only meaningful when onehot_single(v).
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Advance the one-hot row drive: 0001->0010->0100->1000->0001.
    function automatic logic [3:0] row_rotate(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_debounce_stable_counter.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_debounce_stable_counter
//  Description : Saturating stability counter. Cleared by clear, advances on
//                inc, and raises done once DEBOUNCE_CNT matching cycles have
//                been counted.
//  Ports       : clk, rst (async, active-high), clear, inc -> done
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_debounce_stable_counter #(
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam logic [CNT_W-1:0] c_done_val = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             w_done;

    assign w_done = (r_count == c_done_val);
    assign done   = w_done;

    // Holds at the done value rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && !w_done) begin
            r_count <= r_count + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_debounce
//  Description : 4x4 keypad row sweep with press/release debounce. Emits a
//                one-cycle key_valid strobe with {row,col} key code.
//  Ports       : clk, rst (async, active-high)
//                col_in    [3:0] in  column lines, active-high
//                row_sweep [3:0] out one-hot row drive
//                key_code  [3:0] out {row_idx, col_idx} of last accepted key
//                key_valid       out one-cycle accept strobe
//                key_held        out high while accepted key is down
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_debounce
    import keypad_scan_debounce_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_sweep,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_dwell;
    logic [3:0]       r_row;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    logic             w_dwell_last;
    logic             w_col_single;
    logic [1:0]       w_col_idx;
    logic [3:0]       w_latched_col;
    logic             w_db_clear;
    logic             w_db_inc;
    logic             w_db_done;
    logic             w_scan_hit;
    logic             w_scan_miss;
    logic             w_press_abort;
    logic             w_accept;
    logic             w_rel_done;

    assign w_dwell_last  = (r_dwell == c_dwell_last);
    assign w_col_single  = onehot_single(col_in);
    assign w_col_idx     = onehot_index(col_in);
    assign w_latched_col = 4'b0001 << r_col_idx;

    assign w_scan_hit    = (r_state == c_st_scan) && w_dwell_last && w_col_single;
    assign w_scan_miss   = (r_state == c_st_scan) && w_dwell_last && !w_col_single;
    assign w_accept      = (r_state == c_st_press_db) && w_db_done;
    assign w_press_abort = (r_state == c_st_press_db) && !w_db_done &&
                           (col_in != w_latched_col);
    assign w_rel_done    = (r_state == c_st_rel_db) && w_db_done;

    // One counter serves both debounce states; it is held clear in the
    // non-debounce states so every debounce window starts from zero.
    keypad_scan_debounce_stable_counter #(
        .CNT_W        (CNT_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_stable_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_db_clear),
        .inc   (w_db_inc),
        .done  (w_db_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_scan;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Reaching the count takes priority over the current column sample:
    // DEBOUNCE_CNT matching cycles have already been seen at that point.
    always_comb begin
        w_next_state = r_state;
        w_db_clear   = 1'b0;
        w_db_inc     = 1'b0;
        case (r_state)
            c_st_scan: begin
                w_db_clear = 1'b1;
                if (w_dwell_last && w_col_single) w_next_state = c_st_press_db;
            end
            c_st_press_db: begin
                if (w_db_done)                       w_next_state = c_st_pressed;
                else if (col_in == w_latched_col)    w_db_inc     = 1'b1;
                else                                 w_next_state = c_st_scan;
            end
            c_st_pressed: begin
                w_db_clear = 1'b1;
                if (col_in == 4'd0) w_next_state = c_st_rel_db;
            end
            c_st_rel_db: begin
                if (w_db_done)            w_next_state = c_st_scan;
                else if (col_in == 4'd0)  w_db_inc     = 1'b1;
                else                      w_next_state = c_st_pressed;
            end
            default: w_next_state = c_st_scan;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell     <= '0;
            r_row       <= c_row_reset;
            r_col_idx   <= 2'd0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= w_accept;

            // Dwell only runs while sweeping; any other state leaves it at
            // zero so a return to scanning starts a full dwell period.
            if ((r_state == c_st_scan) && !w_dwell_last) begin
                r_dwell <= r_dwell + c_cnt_one;
            end else begin
                r_dwell <= '0;
            end

            if (w_scan_hit) r_col_idx <= w_col_idx;

            // Row stays frozen from the hit until the key is fully released
            // (or the press is rejected), so it still names the key's row.
            if (w_scan_miss || w_press_abort || w_rel_done) begin
                r_row <= row_rotate(r_row);
            end

            if (w_accept) begin
                r_key_code <= {onehot_index(r_row), r_col_idx};
                r_key_held <= 1'b1;
            end else if (w_rel_done) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign row_sweep = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_debounce
//  Description : Self-checking bench for keypad_scan_debounce with a
//                behavioural model, directed scenarios and random stimulus.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int CNT_W        = 16;

    localparam int PH_SCAN = 0;
    localparam int PH_PDB  = 1;
    localparam int PH_HELD = 2;
    localparam int PH_RDB  = 3;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] col_in = 4'd0;
    logic [3:0] row_sweep;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    keypad_scan_debounce #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_sweep (row_sweep),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // ---------------- behavioural model ----------------
    int         m_phase = PH_SCAN;
    int         m_row   = 0;
    int         m_dwell = 0;
    int         m_run   = 0;
    int         m_col   = 0;
    logic [3:0] m_code  = 4'h0;
    logic       m_valid = 1'b0;
    logic       m_held  = 1'b0;

    function automatic int lowest_bit(input logic [3:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = PH_SCAN; m_row = 0; m_dwell = 0; m_run = 0; m_col = 0;
        m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] c);
        m_valid = 1'b0;
        case (m_phase)
            PH_SCAN: begin
                if (m_dwell == SCAN_DIV - 1) begin
                    m_dwell = 0;
                    if ($countones(c) == 1) begin
                        m_col = lowest_bit(c); m_run = 0; m_phase = PH_PDB;
                    end else begin
                        m_row = (m_row + 1) % 4;
                    end
                end else begin
                    m_dwell++;
                end
            end
            PH_PDB: begin
                if (m_run == DEBOUNCE_CNT) begin
                    m_valid = 1'b1; m_code = 4'(m_row * 4 + m_col);
                    m_held = 1'b1; m_phase = PH_HELD;
                end else if (int'(c) == (1 << m_col)) begin
                    m_run++;
                end else begin
                    m_phase = PH_SCAN; m_dwell = 0; m_row = (m_row + 1) % 4;
                end
            end
            PH_HELD: begin
                if (c == 4'd0) begin m_phase = PH_RDB; m_run = 0; end
            end
            default: begin
                if (m_run == DEBOUNCE_CNT) begin
                    m_held = 1'b0; m_phase = PH_SCAN; m_dwell = 0;
                    m_row = (m_row + 1) % 4;
                end else if (c == 4'd0) begin
                    m_run++;
                end else begin
                    m_phase = PH_HELD;
                end
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step(col_in);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("row_sweep", 32'(row_sweep), 32'(1 << m_row));
            check("key_code",  32'(key_code),  32'(m_code));
            check("key_valid", 32'(key_valid), 32'(m_valid));
            check("key_held",  32'(key_held),  32'(m_held));
            if (key_valid === 1'b1) n_pulses++;
        end
    end

    // Wait until the row drive just switched to target (dwell at zero).
    task automatic wait_row_start(input logic [3:0] target);
        logic [3:0] prev;
        bit         found;
        prev  = row_sweep;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (row_sweep == target && prev != target) found = 1'b1;
            prev = row_sweep;
        end
        check("wait_row_found", 32'(found), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int base;
    int changes;
    logic [3:0] prev_row;

    initial begin
        // 1: reset then free-running sweep
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check("t1_row", 32'(row_sweep), 32'(4'b0001 << ((k / 4) % 4)));
        end
        check("t1_held", 32'(key_held), 32'd0);
        #1 check("t1_pulses", 32'(n_pulses), 32'd0);

        // 2: clean press of column 2 in row 0, then release
        wait_row_start(4'b0001);
        col_in = 4'b0100;
        base = n_pulses;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 12) check("t2_not_early", 32'(key_valid), 32'd0);
            if (k == 13) begin
                check("t2_valid", 32'(key_valid), 32'd1);
                check("t2_code",  32'(key_code),  32'h2);
                check("t2_held",  32'(key_held),  32'd1);
                check("t2_frozen", 32'(row_sweep), 32'b0001);
                check("t2_model_code", 32'(m_code), 32'h2);
            end
            if (k == 14) check("t2_one_cycle", 32'(key_valid), 32'd0);
        end
        col_in = 4'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 9)  check("t2_held_in_rel", 32'(key_held), 32'd1);
            if (k == 10) begin
                check("t2_released", 32'(key_held), 32'd0);
                check("t2_next_row", 32'(row_sweep), 32'b0010);
            end
        end
        #1 check("t2_pulses", 32'(n_pulses - base), 32'd1);

        // 3: bouncing press is rejected, then a stable press in row 3
        wait_row_start(4'b1000);
        col_in = 4'b1000;
        base = n_pulses;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 7) begin
                check("t3_resume_row", 32'(row_sweep), 32'b0001);
                check("t3_no_held", 32'(key_held), 32'd0);
            end
            if (k >= 6) col_in = (((k - 6) / 3) % 2 == 0) ? 4'b0000 : 4'b1000;
        end
        col_in = 4'd0;
        #1 check("t3_bounce_pulses", 32'(n_pulses - base), 32'd0);
        wait_row_start(4'b1000);
        col_in = 4'b1000;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 13) begin
                check("t3_valid", 32'(key_valid), 32'd1);
                check("t3_code",  32'(key_code),  32'hF);
            end
        end
        col_in = 4'd0;
        repeat (12) @(negedge clk);
        #1 check("t3_pulses", 32'(n_pulses - base), 32'd1);

        // 4: release bounce keeps key_held and gives no second strobe
        wait_row_start(4'b0010);
        col_in = 4'b0001;
        base = n_pulses;
        repeat (15) @(negedge clk);
        col_in = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t4_held_bounce", 32'(key_held), 32'd1);
        end
        col_in = 4'b0001;
        repeat (3) @(negedge clk);
        col_in = 4'd0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 9)  check("t4_held_late", 32'(key_held), 32'd1);
            if (k == 10) check("t4_released", 32'(key_held), 32'd0);
        end
        check("t4_code", 32'(key_code), 32'h4);
        #1 check("t4_pulses", 32'(n_pulses - base), 32'd1);

        // 5: multi-column input is ignored
        col_in = 4'b0011;
        base = n_pulses;
        changes = 0;
        prev_row = row_sweep;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (row_sweep != prev_row) changes++;
            prev_row = row_sweep;
        end
        col_in = 4'd0;
        check("t5_rotations", 32'(changes >= 24 && changes <= 25), 32'd1);
        #1 check("t5_pulses", 32'(n_pulses - base), 32'd0);

        // 6: async reset in the middle of press debounce
        wait_row_start(4'b0100);
        col_in = 4'b0010;
        base = n_pulses;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_row_rst",   32'(row_sweep), 32'b0001);
        check("t6_code_rst",  32'(key_code),  32'h0);
        check("t6_valid_rst", 32'(key_valid), 32'd0);
        check("t6_held_rst",  32'(key_held),  32'd0);
        repeat (3) @(negedge clk);
        col_in = 4'd0;
        rst = 1'b0;
        check("t6_restart_row", 32'(row_sweep), 32'b0001);
        repeat (20) @(negedge clk);
        #1 check("t6_pulses", 32'(n_pulses - base), 32'd0);

        // Random stimulus against the model
        for (int it = 0; it < 150; it++) begin
            int kind;
            int hold;
            kind = int'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 30));
            @(negedge clk);
            case (kind)
                0:       col_in = 4'd0;
                1, 2:    col_in = 4'b0001 << $urandom_range(0, 3);
                default: col_in = 4'($urandom_range(0, 15));
            endcase
            repeat (hold) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                #3 rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        col_in = 4'd0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
